// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_ws_ctrl data memory controller.
// Optional build macro: DMEM_MISALIGN_SPLIT_EN (see dmem_ws_ctrl.sv).
package dmem_pkg;

    typedef enum logic [1:0] {
        LEN_B   = 2'b00,
        LEN_H   = 2'b01,
        LEN_W   = 2'b10,
        LEN_BAD = 2'b11
    } dmem_len_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACC0 = 3'd2,
        ACC1 = 3'd3,
        RESP = 3'd4
    } dmem_state_e;

    // Byte enables over two consecutive words: [3:0] low word, [7:4] next word.
    function automatic logic [7:0] lane_mask(input dmem_len_e len, input logic [1:0] off);
        logic [7:0] base;
        case (len)
            LEN_B:   base = 8'b0000_0001;
            LEN_H:   base = 8'b0000_0011;
            LEN_W:   base = 8'b0000_1111;
            default: base = 8'b0000_0000;
        endcase
        return base << off;
    endfunction

    // Extend LSB-aligned load data to 32 bits according to size and signedness.
    function automatic logic [31:0] load_extend(input logic [31:0] data, input dmem_len_e len,
                                                input logic sign);
        logic [31:0] res;
        case (len)
            LEN_B:   res = {{24{sign & data[7]}}, data[7:0]};
            LEN_H:   res = {{16{sign & data[15]}}, data[15:0]};
            LEN_W:   res = data;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_ws_ctrl_if.sv
// Request/response bundle between the core MEM stage (master) and dmem_ws_ctrl (slave).
interface dmem_ws_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [1:0]  req_len;
    logic        req_sign;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_len, req_sign, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_len, req_sign, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_sram_bank.sv
// Single-port 32-bit word array with byte write enables and a registered read port.
// Contents are never reset.
module dmem_sram_bank #(
    parameter int    ADDR_W    = 14,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem_r [2**ADDR_W];
    logic [31:0] rdata_q;

    // One port operation per edge: byte-lane write, or word read when no lane is enabled.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we != 4'b0000) begin
                for (int i = 0; i < 4; i++) begin
                    if (we[i]) begin
                        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_r[addr];
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/dmem_ws_ctrl.sv
// Wait-state data memory controller: req/resp handshake, LB/LH/LW and SB/SH/SW.
// Build macro DMEM_MISALIGN_SPLIT_EN: word-crossing accesses take two beats instead of erroring.
module dmem_ws_ctrl
    import dmem_pkg::*;
#(
    parameter int    ADDR_W      = 14,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic           clk,
    input  logic           rst,
    dmem_ws_ctrl_if.slave  bus
);
    localparam int AW = ADDR_W + 2;

    dmem_state_e   state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    dmem_len_e     len_q, len_d;
    logic          sign_q, sign_d;
    logic          wr_q, wr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   lo_q, lo_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic              accept_s, bad_s, split_s, unused_addr_s;
    dmem_len_e         req_len_s;
    logic [7:0]        mask_s;
    logic [ADDR_W-1:0] word_s, word_nxt_s;
    logic [63:0]       wide_wdata_s, wide_rdata_s, shifted_s;
    logic [31:0]       load_s;
    logic              bank_en_s;
    logic [3:0]        bank_we_s;
    logic [ADDR_W-1:0] bank_addr_s;
    logic [31:0]       bank_wdata_s, bank_rdata_s;

    assign accept_s      = bus.req_valid && (state_q == IDLE);
    assign req_len_s     = dmem_len_e'(bus.req_len);
    assign unused_addr_s = ^bus.req_addr[31:AW];
    assign mask_s        = lane_mask(len_q, addr_q[1:0]);
    assign word_s        = addr_q[AW-1:2];
    assign word_nxt_s    = word_s + ADDR_W'(1);
    assign wide_wdata_s  = {32'h0000_0000, wdata_q} << {addr_q[1:0], 3'b000};

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign bad_s   = (req_len_s == LEN_BAD);
    assign split_s = (mask_s[7:4] != 4'b0000);
`else
    assign bad_s   = (req_len_s == LEN_BAD) ||
                     ((req_len_s == LEN_H) && bus.req_addr[0]) ||
                     ((req_len_s == LEN_W) && (bus.req_addr[1:0] != 2'b00));
    assign split_s = 1'b0;
`endif

    // Assemble load bytes from one or two words and extend them.
    always_comb begin
        if (state_q == ACC1) begin
            wide_rdata_s = {bank_rdata_s, lo_q};
        end else begin
            wide_rdata_s = {32'h0000_0000, bank_rdata_s};
        end
        shifted_s = wide_rdata_s >> {addr_q[1:0], 3'b000};
        load_s    = load_extend(shifted_s[31:0], len_q, sign_q);
    end

    // Next-state logic: capture at acceptance, wait states, beats, one-cycle response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        sign_d       = sign_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0000_0000;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    addr_d  = bus.req_addr[AW-1:0];
                    len_d   = req_len_s;
                    sign_d  = bus.req_sign;
                    wr_d    = bus.req_wr;
                    wdata_d = bus.req_wdata;
                    if (bad_s) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (WAIT_CYCLES == 0) begin
                        state_d = ACC0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 8'(WAIT_CYCLES - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ACC0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACC0: begin
                lo_d = bank_rdata_s;
                if (split_s) begin
                    state_d = ACC1;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wr_q ? 32'h0000_0000 : load_s;
                end
            end
            ACC1: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = wr_q ? 32'h0000_0000 : load_s;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Array port: stores write during the beat itself, loads are launched on the edge entering it.
    always_comb begin
        bank_en_s    = 1'b0;
        bank_we_s    = 4'b0000;
        bank_addr_s  = addr_d[AW-1:2];
        bank_wdata_s = 32'h0000_0000;
        if (wr_q && (state_q == ACC0)) begin
            bank_en_s    = 1'b1;
            bank_we_s    = mask_s[3:0];
            bank_addr_s  = word_s;
            bank_wdata_s = wide_wdata_s[31:0];
        end else if (wr_q && (state_q == ACC1)) begin
            bank_en_s    = 1'b1;
            bank_we_s    = mask_s[7:4];
            bank_addr_s  = word_nxt_s;
            bank_wdata_s = wide_wdata_s[63:32];
        end else if (!wr_d && (state_d == ACC0)) begin
            bank_en_s   = 1'b1;
            bank_addr_s = addr_d[AW-1:2];
        end else if (!wr_d && (state_d == ACC1)) begin
            bank_en_s   = 1'b1;
            bank_addr_s = word_nxt_s;
        end else begin
            bank_en_s = 1'b0;
        end
    end

    // State, captured request and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= '0;
            len_q        <= LEN_B;
            sign_q       <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            lo_q         <= 32'h0000_0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            sign_q       <= sign_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    dmem_sram_bank #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_bank (
        .clk   (clk),
        .en    (bank_en_s),
        .we    (bank_we_s),
        .addr  (bank_addr_s),
        .wdata (bank_wdata_s),
        .rdata (bank_rdata_s)
    );
endmodule

// File: tb/tb_dmem_ws_ctrl.sv
// Directed scoreboard bench for dmem_ws_ctrl (WAIT_CYCLES=2, ADDR_W=14).
module tb_dmem_ws_ctrl;
    localparam int WAITC = 2;
    localparam int L1    = WAITC + 2;
    localparam int L2    = WAITC + 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_ws_ctrl_if bus();

    dmem_ws_ctrl #(
        .ADDR_W      (14),
        .WAIT_CYCLES (WAITC),
        .INIT_FILE   ("")
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, then check the response.
    task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [1:0] len, input logic sign, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
        exp_t e;
        int   cyc;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        check({tag, "/ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_sign  = sign;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wr    = ~wr;
        bus.req_addr  = ~addr;
        bus.req_len   = ~len;
        bus.req_sign  = ~sign;
        bus.req_wdata = ~wdata;
        cyc = 1;
        while (!bus.resp_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        check({tag, "/lat"}, 32'(cyc), 32'(e.lat));
        check({tag, "/rdata"}, bus.resp_rdata, e.rdata);
        check({tag, "/err"}, {31'b0, bus.resp_err}, {31'b0, e.err});
        @(posedge clk);
        #1;
        check({tag, "/pulse"}, {31'b0, bus.resp_valid}, 32'd0);
        check({tag, "/idle"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'h0000_0000;
        bus.req_len   = 2'b00;
        bus.req_sign  = 1'b0;
        bus.req_wdata = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check("rst/resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst/resp_rdata", bus.resp_rdata, 32'd0);
        check("rst/resp_err", {31'b0, bus.resp_err}, 32'd0);
        check("rst/req_ready", {31'b0, bus.req_ready}, 32'd1);
        rst = 1'b0;

        // Word store/load with wait states
        access("t1_sw", 1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, L1);
        access("t1_lw", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, L1);

        // Sub-word loads and byte store
        access("t2_lb_s", 1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0, 32'hFFFF_FFDE, 1'b0, L1);
        access("t2_lb_u", 1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 32'h0000_00DE, 1'b0, L1);
        access("t2_lh_s", 1'b0, 32'h0000_0102, 2'b01, 1'b1, 32'h0, 32'hFFFF_DEAD, 1'b0, L1);
        access("t2_sb", 1'b1, 32'h0000_0101, 2'b00, 1'b0, 32'hFFFF_FF55, 32'h0, 1'b0, L1);
        access("t2_lw", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0, L1);

        // Illegal length
        access("t3_bad", 1'b1, 32'h0000_0100, 2'b11, 1'b0, 32'h0BAD_0BAD, 32'h0, 1'b1, 1);
        access("t3_lw", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'hDEAD_55EF, 1'b0, L1);

        // Misaligned accesses
        access("t4_sw0", 1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, L1);
        access("t4_sw1", 1'b1, 32'h0000_0104, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 1'b0, L1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        access("t4_lw_mis", 1'b0, 32'h0000_0102, 2'b10, 1'b0, 32'h0, 32'h3344_DEAD, 1'b0, L2);
        access("t4_lh_01", 1'b0, 32'h0000_0101, 2'b01, 1'b0, 32'h0, 32'h0000_ADBE, 1'b0, L1);
        access("t4_lh_11", 1'b0, 32'h0000_0103, 2'b01, 1'b1, 32'h0, 32'h0000_44DE, 1'b0, L2);
`else
        access("t4_lw_mis", 1'b0, 32'h0000_0102, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        access("t4_lh_01", 1'b0, 32'h0000_0101, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1, 1);
        access("t4_lh_11", 1'b0, 32'h0000_0103, 2'b01, 1'b1, 32'h0, 32'h0, 1'b1, 1);
`endif

        // Address wrap modulo capacity
        access("t5_sw_wrap", 1'b1, 32'h0001_0000, 2'b10, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0, L1);
        access("t5_lw0", 1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, L1);
`ifdef DMEM_MISALIGN_SPLIT_EN
        access("t5_sw_top", 1'b1, 32'h0000_FFFE, 2'b10, 1'b0, 32'hAABB_CCDD, 32'h0, 1'b0, L2);
        access("t5_lw0b", 1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0, 32'hCAFE_AABB, 1'b0, L1);
`else
        access("t5_sw_top", 1'b1, 32'h0000_FFFE, 2'b10, 1'b0, 32'hAABB_CCDD, 32'h0, 1'b1, 1);
        access("t5_lw0b", 1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, L1);
`endif

        // Reset during the wait phase drops the store and its response
        access("t6_sw_prior", 1'b1, 32'h0000_0200, 2'b10, 1'b0, 32'h1234_5678, 32'h0, 1'b0, L1);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h0000_0200;
        bus.req_len   = 2'b10;
        bus.req_wdata = 32'h0BAD_F00D;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        seen = 0;
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_wdata = 32'hFFFF_FFFF;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid) seen++;
        end
        check("t6_no_resp", 32'(seen), 32'd0);
        check("t6_ready", {31'b0, bus.req_ready}, 32'd1);
        access("t6_lw", 1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, 32'h1234_5678, 1'b0, L1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
